// File: rtl/image_stride_n.sv
// Stride/decimation stage: keeps pixels at row%S==0 and col%S==0 from a raster
// stream of (row, col, channel-group) beats, with S run-time selectable as 1, 2 or 4.
module image_stride_n #(
   parameter int unsigned CH_PAR             = 8,
   parameter int unsigned WIDTH_DATA         = 8,
   parameter int unsigned PICTURE_NUM        = 1,
   parameter int unsigned WIDTH_FEATURE_SIZE = 11,
   parameter int unsigned WIDTH_CH           = 8
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       Start,
   input  logic [1:0]                                 Stride_Mode_REG,
   input  logic [WIDTH_FEATURE_SIZE-1:0]              Row_Num_Out_REG,
   input  logic [WIDTH_CH-1:0]                        Channel_Out_Num_REG,
   input  logic [CH_PAR*WIDTH_DATA*PICTURE_NUM-1:0]   S_Data,
   input  logic                                       S_Valid,
   output logic                                       S_Ready,
   output logic [CH_PAR*WIDTH_DATA*PICTURE_NUM-1:0]   M_Data,
   output logic                                       M_Valid,
   input  logic                                       M_Ready,
   output logic                                       Img_Last,
   output logic                                       Stride_Complete
);

   localparam int unsigned DW  = CH_PAR * WIDTH_DATA * PICTURE_NUM;
   localparam int unsigned WFS = WIDTH_FEATURE_SIZE;
   // One extra bit so C + CH_PAR - 1 cannot overflow before the divide.
   localparam int unsigned WG  = WIDTH_CH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [WFS-1:0]  mask_q;
   logic [WFS-1:0]  w_q;
   logic [WG-1:0]   g_q;
   logic [WG-1:0]   grp_q;
   logic [WFS-1:0]  col_q;
   logic [WFS-1:0]  row_q;
   logic [DW-1:0]   m_data_q;
   logic            m_valid_q;
   logic            img_last_q;
   logic            complete_q;
   logic            complete_d;

   logic [WFS-1:0]  mask_sel;
   logic [WG-1:0]   g_calc;
   logic [WFS-1:0]  last_pos;
   logic            keep;
   logic            accept;
   logic            grp_end;
   logic            col_end;
   logic            row_end;
   logic            frame_end;
   logic            last_kept;
   logic            start_ok;

   // Decode stride mode into a low-bit mask (S-1); reserved mode behaves as S=1.
   always_comb begin
      mask_sel = '0;
      case (Stride_Mode_REG)
         2'd1:    mask_sel = WFS'(1);
         2'd2:    mask_sel = WFS'(3);
         default: mask_sel = '0;
      endcase
   end

   assign g_calc    = (WG'(Channel_Out_Num_REG) + WG'(CH_PAR - 1)) / WG'(CH_PAR);
   assign start_ok  = (state_q == IDLE) && Start;

   // Last kept origin along an axis: W-1 rounded down to a multiple of S.
   assign last_pos  = (w_q - WFS'(1)) & ~mask_q;
   assign keep      = ((row_q & mask_q) == '0) && ((col_q & mask_q) == '0);
   assign S_Ready   = (state_q == RUN) && (!keep || !m_valid_q || M_Ready);
   assign accept    = S_Valid && S_Ready;
   assign grp_end   = (grp_q == g_q - WG'(1));
   assign col_end   = (col_q == w_q - WFS'(1));
   assign row_end   = (row_q == w_q - WFS'(1));
   assign frame_end = accept && grp_end && col_end && row_end;
   assign last_kept = grp_end && (col_q == last_pos) && (row_q == last_pos);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state and completion-pulse decode.
   always_comb begin
      state_d    = state_q;
      complete_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               if ((Row_Num_Out_REG == '0) || (g_calc == '0)) state_d = DONE;
               else                                             state_d = RUN;
            end
         end
         RUN: begin
            if (frame_end) state_d = DONE;
         end
         DONE: begin
            if (!m_valid_q) begin
               complete_d = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Frame configuration latch and raster position counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask_q <= '0;
         w_q    <= '0;
         g_q    <= '0;
         grp_q  <= '0;
         col_q  <= '0;
         row_q  <= '0;
      end else if (start_ok) begin
         mask_q <= mask_sel;
         w_q    <= Row_Num_Out_REG;
         g_q    <= g_calc;
         grp_q  <= '0;
         col_q  <= '0;
         row_q  <= '0;
      end else if (accept) begin
         if (grp_end) begin
            grp_q <= '0;
            if (col_end) begin
               col_q <= '0;
               row_q <= row_q + WFS'(1);
            end else begin
               col_q <= col_q + WFS'(1);
            end
         end else begin
            grp_q <= grp_q + WG'(1);
         end
      end
   end

   // Output register: load on a kept beat, drain on M_Ready, both in one cycle allowed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         img_last_q <= 1'b0;
      end else if (accept && keep) begin
         m_data_q   <= S_Data;
         m_valid_q  <= 1'b1;
         img_last_q <= last_kept;
      end else if (M_Ready) begin
         m_valid_q  <= 1'b0;
         img_last_q <= 1'b0;
      end
   end

   // Registered completion pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) complete_q <= 1'b0;
      else      complete_q <= complete_d;
   end

   assign M_Data          = m_data_q;
   assign M_Valid         = m_valid_q;
   assign Img_Last        = img_last_q;
   assign Stride_Complete = complete_q;

endmodule
